ddc_accum: RTL and testbench

Receiver and integrator for the summed oct-DDC output stream. It accepts 64-bit DDC samples (I in [29:0], Q in [61:32], 30-bit two's complement, sign-extended to 32 bits). It sums a programmable number of consecutive samples per channel and emits one integrated I/Q word per frame through a 4-entry output FIFO with AXI-Stream backpressure. It sits between the DDC core and the DMA/readout path and decimates the DDC rate by the frame length.

---
 rtl/ddc_accum.sv | 163 ++++++++++++++++
 tb/tb_ddc_accum.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddc_accum.sv
// ddc_accum: integrates consecutive DDC I/Q samples over a programmable frame
// length and queues one sign-extended I/Q sum per frame in a small
// first-word-fall-through FIFO with AXI-Stream backpressure.
module ddc_accum #(
  parameter int unsigned ACC_WIDTH  = 48,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 s_axis_aclk,
  input  logic                 s_axis_areset,
  input  logic [63:0]          s_axis_ddc_tdata,
  input  logic                 s_axis_ddc_tvalid,
  output logic                 s_axis_ddc_tready,
  input  logic [LEN_WIDTH-1:0] s_axis_len_tdata,
  input  logic                 s_axis_len_tvalid,
  input  logic                 resync,
  output logic [127:0]         m_axis_acc_tdata,
  output logic                 m_axis_acc_tvalid,
  input  logic                 m_axis_acc_tready,
  output logic                 ovf,
  output logic [15:0]          drop_count
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned WordW = 2 * ACC_WIDTH;

  typedef enum logic [0:0] {StUnconf, StAcc} state_e;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;
  logic [ACC_WIDTH-1:0] acc_i_q, acc_i_d;
  logic [ACC_WIDTH-1:0] acc_q_q, acc_q_d;
  logic                 ovf_q, ovf_d;
  logic [15:0]          drop_q, drop_d;

  logic [WordW-1:0]     mem_q [FIFO_DEPTH];
  logic [PtrW:0]        wr_ptr_q, rd_ptr_q;

  logic [ACC_WIDTH-1:0] sample_i, sample_q;
  logic [ACC_WIDTH-1:0] base_i, base_q, sum_i, sum_q;
  logic [LEN_WIDTH-1:0] base_cnt, len_m1;
  logic                 push, push_ok, pop, fifo_full, fifo_empty;
  logic [WordW-1:0]     push_word, head_word;
  logic                 unused_bits;

  assign unused_bits = ^{s_axis_ddc_tdata[63:62], s_axis_ddc_tdata[31:30]};

  assign s_axis_ddc_tready = 1'b1;

  assign sample_i = {{(ACC_WIDTH-30){s_axis_ddc_tdata[29]}}, s_axis_ddc_tdata[29:0]};
  assign sample_q = {{(ACC_WIDTH-30){s_axis_ddc_tdata[61]}}, s_axis_ddc_tdata[61:32]};

  // A zero length behaves as a one-sample frame.
  assign len_m1 = (len_q == '0) ? '0 : len_q - LEN_WIDTH'(1);

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign pop        = !fifo_empty && m_axis_acc_tready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok    = push && (!fifo_full || pop);

  // Frame accumulation, length capture and drop accounting.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    count_d   = count_q;
    acc_i_d   = acc_i_q;
    acc_q_d   = acc_q_q;
    ovf_d     = ovf_q;
    drop_d    = drop_q;
    push      = 1'b0;
    base_i    = resync ? '0 : acc_i_q;
    base_q    = resync ? '0 : acc_q_q;
    base_cnt  = resync ? '0 : count_q;
    sum_i     = base_i + sample_i;
    sum_q     = base_q + sample_q;
    push_word = {sum_q, sum_i};

    if (s_axis_len_tvalid) begin
      // Length write wins over resync and swallows a same-cycle sample.
      state_d = StAcc;
      len_d   = s_axis_len_tdata;
      count_d = '0;
      acc_i_d = '0;
      acc_q_d = '0;
      ovf_d   = 1'b0;
      drop_d  = '0;
    end else if (state_q == StAcc) begin
      acc_i_d = base_i;
      acc_q_d = base_q;
      count_d = base_cnt;
      if (s_axis_ddc_tvalid) begin
        if (base_cnt == len_m1) begin
          push    = 1'b1;
          acc_i_d = '0;
          acc_q_d = '0;
          count_d = '0;
        end else begin
          acc_i_d = sum_i;
          acc_q_d = sum_q;
          count_d = base_cnt + LEN_WIDTH'(1);
        end
      end
      if (push && !push_ok) begin
        ovf_d = 1'b1;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
    end
  end

  // Control and accumulator state.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state_q <= StUnconf;
      len_q   <= '0;
      count_q <= '0;
      acc_i_q <= '0;
      acc_q_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Output FIFO storage and pointers; storage cleared so tdata reads 0 after reset.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q[PtrW-1:0]] <= push_word;
        wr_ptr_q <= wr_ptr_q + (PtrW+1)'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
    end
  end

  assign head_word = mem_q[rd_ptr_q[PtrW-1:0]];

  // Each ACC_WIDTH sum is sign-extended into its 64-bit lane.
  always_comb begin
    m_axis_acc_tdata[63:0]   = {{(64-ACC_WIDTH){head_word[ACC_WIDTH-1]}},
                                head_word[ACC_WIDTH-1:0]};
    m_axis_acc_tdata[127:64] = {{(64-ACC_WIDTH){head_word[WordW-1]}},
                                head_word[WordW-1:ACC_WIDTH]};
  end

  assign m_axis_acc_tvalid = !fifo_empty;
  assign ovf               = ovf_q;
  assign drop_count        = drop_q;

endmodule

// File: tb/tb_ddc_accum.sv
// tb_ddc_accum: scoreboard bench for ddc_accum. A frame model pushes expected
// words when samples are driven; a negedge monitor pops them on each transfer.
module tb_ddc_accum;

  localparam int unsigned FifoDepth = 4;

  logic         s_axis_aclk = 1'b0;
  logic         s_axis_areset = 1'b1;
  logic [63:0]  s_axis_ddc_tdata = '0;
  logic         s_axis_ddc_tvalid = 1'b0;
  logic         s_axis_ddc_tready;
  logic [15:0]  s_axis_len_tdata = '0;
  logic         s_axis_len_tvalid = 1'b0;
  logic         resync = 1'b0;
  logic [127:0] m_axis_acc_tdata;
  logic         m_axis_acc_tvalid;
  logic         m_axis_acc_tready = 1'b1;
  logic         ovf;
  logic [15:0]  drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] exp_q [$];
  logic         m_conf = 1'b0;
  int           m_lenm1 = 0;
  int           m_cnt = 0;
  longint       m_ai = 0;
  longint       m_aq = 0;
  int           m_drops = 0;

  ddc_accum #(
    .ACC_WIDTH (48),
    .LEN_WIDTH (16),
    .FIFO_DEPTH(FifoDepth)
  ) dut (
    .s_axis_aclk      (s_axis_aclk),
    .s_axis_areset    (s_axis_areset),
    .s_axis_ddc_tdata (s_axis_ddc_tdata),
    .s_axis_ddc_tvalid(s_axis_ddc_tvalid),
    .s_axis_ddc_tready(s_axis_ddc_tready),
    .s_axis_len_tdata (s_axis_len_tdata),
    .s_axis_len_tvalid(s_axis_len_tvalid),
    .resync           (resync),
    .m_axis_acc_tdata (m_axis_acc_tdata),
    .m_axis_acc_tvalid(m_axis_acc_tvalid),
    .m_axis_acc_tready(m_axis_acc_tready),
    .ovf              (ovf),
    .drop_count       (drop_count)
  );

  always #5 s_axis_aclk = ~s_axis_aclk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint sx30(input logic [29:0] v);
    return longint'(signed'(v));
  endfunction

  task automatic step();
    @(posedge s_axis_aclk);
    #1;
  endtask

  // Pop and compare on every completed output transfer.
  always @(negedge s_axis_aclk) begin
    if (!s_axis_areset && m_axis_acc_tvalid && m_axis_acc_tready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got %h expected none", m_axis_acc_tdata);
      end else begin
        check_eq("word", m_axis_acc_tdata, exp_q.pop_front());
      end
    end
  end

  task automatic model_clear();
    m_cnt = 0;
    m_ai  = 0;
    m_aq  = 0;
  endtask

  task automatic len_write(input int l);
    s_axis_len_tdata  = 16'(l);
    s_axis_len_tvalid = 1'b1;
    m_conf  = 1'b1;
    m_lenm1 = (l == 0) ? 0 : l - 1;
    m_drops = 0;
    model_clear();
    step();
    s_axis_len_tvalid = 1'b0;
  endtask

  task automatic drive_sample(input logic [29:0] si, input logic [29:0] sq, input logic rs);
    // Ignored fields carry junk to prove they do not leak into the sums.
    s_axis_ddc_tdata  = {2'b01, sq, 2'b10, si};
    s_axis_ddc_tvalid = 1'b1;
    resync            = rs;
    if (m_conf) begin
      if (rs) model_clear();
      m_ai += sx30(si);
      m_aq += sx30(sq);
      if (m_cnt == m_lenm1) begin
        if (exp_q.size() >= FifoDepth && !m_axis_acc_tready) begin
          if (m_drops != 65535) m_drops++;
        end else begin
          exp_q.push_back({m_aq, m_ai});
        end
        model_clear();
      end else begin
        m_cnt++;
      end
    end
    step();
    s_axis_ddc_tvalid = 1'b0;
    resync            = 1'b0;
  endtask

  task automatic do_reset();
    s_axis_areset = 1'b1;
    exp_q.delete();
    m_conf  = 1'b0;
    m_drops = 0;
    model_clear();
    step();
    s_axis_areset = 1'b0;
    step();
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_axis_acc_tvalid) && n < 100) begin
      step();
      n++;
    end
    check_eq("drain_tvalid", 128'(m_axis_acc_tvalid), 128'(0));
    check_eq("drain_queue", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    longint ei, eq;
    step();
    check_eq("rst_tready", 128'(s_axis_ddc_tready), 128'(1));
    check_eq("rst_tvalid", 128'(m_axis_acc_tvalid), 128'(0));
    check_eq("rst_tdata", m_axis_acc_tdata, 128'(0));
    check_eq("rst_ovf", 128'(ovf), 128'(0));
    check_eq("rst_drops", 128'(drop_count), 128'(0));
    s_axis_areset = 1'b0;
    step();

    // Unconfigured: samples are discarded.
    for (int k = 0; k < 3; k++) drive_sample(30'd9, 30'd9, 1'b0);
    step();
    check_eq("unconf_tvalid", 128'(m_axis_acc_tvalid), 128'(0));

    // Basic frame.
    m_axis_acc_tready = 1'b1;
    len_write(4);
    for (int k = 1; k <= 4; k++) drive_sample(30'(k), 30'h3FFF_FFFF, 1'b0);
    check_eq("basic_tvalid", 128'(m_axis_acc_tvalid), 128'(1));
    check_eq("basic_word", m_axis_acc_tdata, {64'hFFFF_FFFF_FFFF_FFFC, 64'd10});
    wait_drain();

    // Extremes at the longest frame.
    len_write(65535);
    for (int k = 0; k < 65535; k++) drive_sample(30'h1FFF_FFFF, 30'h2000_0000, 1'b0);
    ei = 64'd65535 * 64'd536870911;
    eq = -(64'sd65535 * 64'sd536870912);
    check_eq("ext_tvalid", 128'(m_axis_acc_tvalid), 128'(1));
    check_eq("ext_word", m_axis_acc_tdata, {eq, ei});
    wait_drain();

    // Backpressure with drops.
    m_axis_acc_tready = 1'b0;
    len_write(1);
    for (int k = 0; k < 6; k++) drive_sample(30'(100 + k), 30'(-k), 1'b0);
    check_eq("bp_ovf", 128'(ovf), 128'(1));
    check_eq("bp_drops", 128'(drop_count), 128'(2));
    check_eq("bp_drops_model", 128'(drop_count), 128'(m_drops));
    check_eq("bp_held", m_axis_acc_tdata, {64'd0, 64'd100});
    step();
    check_eq("bp_stable", m_axis_acc_tdata, {64'd0, 64'd100});
    m_axis_acc_tready = 1'b1;
    wait_drain();

    // Push and pop in the same cycle while full.
    m_axis_acc_tready = 1'b0;
    len_write(1);
    check_eq("len_clears_ovf", 128'(ovf), 128'(0));
    check_eq("len_clears_drops", 128'(drop_count), 128'(0));
    for (int k = 0; k < 4; k++) drive_sample(30'(k + 1), 30'(k + 2), 1'b0);
    m_axis_acc_tready = 1'b1;
    drive_sample(30'd77, 30'h3FFF_FFF0, 1'b0);
    check_eq("pp_ovf", 128'(ovf), 128'(0));
    check_eq("pp_drops", 128'(drop_count), 128'(0));
    wait_drain();

    // resync mid-frame.
    len_write(4);
    drive_sample(30'd5, 30'd0, 1'b0);
    drive_sample(30'd5, 30'd0, 1'b0);
    drive_sample(30'd7, 30'd0, 1'b1);
    for (int k = 0; k < 3; k++) drive_sample(30'd1, 30'd0, 1'b0);
    check_eq("rs_tvalid", 128'(m_axis_acc_tvalid), 128'(1));
    check_eq("rs_word", m_axis_acc_tdata, {64'd0, 64'd10});
    wait_drain();

    // Reset with two words held and a frame in progress.
    m_axis_acc_tready = 1'b0;
    len_write(1);
    drive_sample(30'd3, 30'd4, 1'b0);
    drive_sample(30'd5, 30'd6, 1'b0);
    len_write(3);
    drive_sample(30'd1, 30'd1, 1'b0);
    check_eq("pre_rst_tvalid", 128'(m_axis_acc_tvalid), 128'(1));
    #2;
    s_axis_areset = 1'b1;
    exp_q.delete();
    m_conf = 1'b0;
    model_clear();
    #1;
    check_eq("midrst_tvalid", 128'(m_axis_acc_tvalid), 128'(0));
    check_eq("midrst_ovf", 128'(ovf), 128'(0));
    step();
    s_axis_areset = 1'b0;
    m_axis_acc_tready = 1'b1;
    for (int k = 0; k < 4; k++) drive_sample(30'd2, 30'd2, 1'b0);
    step();
    check_eq("postrst_tvalid", 128'(m_axis_acc_tvalid), 128'(0));
    len_write(2);
    drive_sample(30'd3, 30'h3FFF_FFFE, 1'b0);
    drive_sample(30'd4, 30'h3FFF_FFFD, 1'b0);
    check_eq("resume_tvalid", 128'(m_axis_acc_tvalid), 128'(1));
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
